// File: rtl/cla_pkg.sv
// Shared definitions for the multi-word carry-lookahead sequencer:
// adder slice width and FSM state encoding.
package cla_pkg;

  localparam int CLA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/Carry_Lookahead_Adder_16.sv
// 16-bit carry-lookahead adder built from four 4-bit lookahead blocks,
// exporting group generate/propagate so callers can chain words.
module Carry_Lookahead_Adder_16
  import cla_pkg::*;
(
  input  logic [CLA_W-1:0] A,
  input  logic [CLA_W-1:0] B,
  input  logic             C0,
  output logic [CLA_W-1:0] S,
  output logic [CLA_W-1:0] C,
  output logic             G,
  output logic             P
);

  logic [CLA_W-1:0] g_s;
  logic [CLA_W-1:0] p_s;
  logic [3:0]       gb_s;
  logic [3:0]       pb_s;
  logic [3:0]       cb_s;
  logic             c_run_s;

  // Bit and block generate/propagate, block carries, sum and group outputs
  always_comb begin
    g_s     = A & B;
    p_s     = A ^ B;
    gb_s    = 4'd0;
    pb_s    = 4'd0;
    cb_s    = 4'd0;
    c_run_s = 1'b0;
    C       = 16'd0;
    for (int k = 0; k < 4; k++) begin
      gb_s[k] = g_s[4*k+3]
              | (p_s[4*k+3] & g_s[4*k+2])
              | (p_s[4*k+3] & p_s[4*k+2] & g_s[4*k+1])
              | (p_s[4*k+3] & p_s[4*k+2] & p_s[4*k+1] & g_s[4*k]);
      pb_s[k] = &p_s[4*k +: 4];
    end
    // Second-level lookahead across the four blocks
    cb_s[0] = C0;
    cb_s[1] = gb_s[0] | (pb_s[0] & C0);
    cb_s[2] = gb_s[1] | (pb_s[1] & gb_s[0]) | (pb_s[1] & pb_s[0] & C0);
    cb_s[3] = gb_s[2] | (pb_s[2] & gb_s[1]) | (pb_s[2] & pb_s[1] & gb_s[0])
            | (pb_s[2] & pb_s[1] & pb_s[0] & C0);
    for (int k = 0; k < 4; k++) begin
      c_run_s = cb_s[k];
      for (int j = 0; j < 4; j++) begin
        c_run_s     = g_s[4*k+j] | (p_s[4*k+j] & c_run_s);
        C[4*k+j]    = c_run_s;
      end
    end
    S = p_s ^ {C[CLA_W-2:0], C0};
    G = gb_s[3] | (pb_s[3] & gb_s[2]) | (pb_s[3] & pb_s[2] & gb_s[1])
      | (pb_s[3] & pb_s[2] & pb_s[1] & gb_s[0]);
    P = &pb_s;
  end

endmodule

// File: rtl/cla_multiword_seq.sv
// Wide add/subtract sequencer: one 16-bit CLA reused over WORDS cycles,
// LS word first, with a registered inter-word carry and valid/ready channels.
module cla_multiword_seq
  import cla_pkg::*;
#(
  parameter int WORDS = 4,
  parameter int IDX_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic                   op_sub,
  input  logic                   cin,
  input  logic [CLA_W*WORDS-1:0] a_in,
  input  logic [CLA_W*WORDS-1:0] b_in,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [CLA_W*WORDS-1:0] sum,
  output logic                   cout,
  output logic                   ovf,
  output logic                   busy
);

  localparam int W = CLA_W * WORDS;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             op_sub_q, op_sub_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CLA_W-1:0] a_word_s;
  logic [CLA_W-1:0] b_eff_s;
  logic [CLA_W-1:0] cla_s_s;
  logic [CLA_W-1:0] cla_c_unused_s;
  logic             cla_g_s;
  logic             cla_p_s;
  logic             word_cout_s;
  logic             last_word_s;

  // Select the current word and apply the subtract inversion to B
  always_comb begin
    a_word_s    = a_q[CLA_W*int'(idx_q) +: CLA_W];
    b_eff_s     = b_q[CLA_W*int'(idx_q) +: CLA_W] ^ {CLA_W{op_sub_q}};
    word_cout_s = cla_g_s | (cla_p_s & carry_q);
    last_word_s = (idx_q == IDX_W'(WORDS-1));
  end

  Carry_Lookahead_Adder_16 u_cla (
    .A  (a_word_s),
    .B  (b_eff_s),
    .C0 (carry_q),
    .S  (cla_s_s),
    .C  (cla_c_unused_s),
    .G  (cla_g_s),
    .P  (cla_p_s)
  );

  // Next-state logic for the FSM, word index and datapath registers
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    op_sub_d = op_sub_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          a_d      = a_in;
          b_d      = b_in;
          op_sub_d = op_sub;
          carry_d  = op_sub ? 1'b1 : cin;
          idx_d    = {IDX_W{1'b0}};
          sum_d    = {W{1'b0}};
          cout_d   = 1'b0;
          ovf_d    = 1'b0;
          state_d  = ST_CALC;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_CALC: begin
        sum_d[CLA_W*int'(idx_q) +: CLA_W] = cla_s_s;
        carry_d = word_cout_s;
        idx_d   = idx_q + IDX_W'(1);
        if (last_word_s) begin
          cout_d  = word_cout_s;
          ovf_d   = (a_word_s[CLA_W-1] == b_eff_s[CLA_W-1]) &&
                    (cla_s_s[CLA_W-1] != a_word_s[CLA_W-1]);
          state_d = ST_DONE;
        end else begin
          state_d = ST_CALC;
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= {IDX_W{1'b0}};
      carry_q  <= 1'b0;
      op_sub_q <= 1'b0;
      a_q      <= {W{1'b0}};
      b_q      <= {W{1'b0}};
      sum_q    <= {W{1'b0}};
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      op_sub_q <= op_sub_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign start_ready = (state_q == ST_IDLE);
  assign res_valid   = (state_q == ST_DONE);
  assign busy        = (state_q != ST_IDLE);
  assign sum         = sum_q;
  assign cout        = cout_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_cla_multiword_seq.sv
// Self-checking bench for cla_multiword_seq (WORDS=4): directed vector table,
// randomized ops against a wide-arithmetic model, backpressure and reset abort.
module tb_cla_multiword_seq;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic         op_sub;
  logic         cin;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic [W-1:0] e_sum;
    logic         e_cout;
    logic         e_ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  cla_multiword_seq #(.WORDS(WORDS), .IDX_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_sub      (op_sub),
    .cin         (cin),
    .a_in        (a_in),
    .b_in        (b_in),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum         (sum),
    .cout        (cout),
    .ovf         (ovf),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_w(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sub, input logic ci);
    exp_t         e;
    logic [W:0]   t;
    logic [W-1:0] be;
    be     = sub ? ~b : b;
    t      = {1'b0, a} + {1'b0, be} + (W+1)'(sub ? 1'b1 : ci);
    e.sum  = t[W-1:0];
    e.cout = t[W];
    e.ovf  = (a[W-1] == be[W-1]) && (t[W-1] != a[W-1]);
    return e;
  endfunction

  // Present a request at a negedge, push its expectation on the accepting edge
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic sub, input logic ci, input exp_t e);
    @(negedge clk);
    check_b("start_ready_before_accept", start_ready, 1'b1);
    a_in = a; b_in = b; op_sub = sub; cin = ci; start_valid = 1'b1;
    @(posedge clk);
    sb.push_back(e);
    #1;
    start_valid = 1'b0;
    a_in = {$urandom, $urandom}; b_in = {$urandom, $urandom};
    op_sub = 1'(~sub); cin = 1'(~ci);
  endtask

  // Wait for the result (accept edge counts as edge 1), compare, then handshake
  task automatic collect(input int hold);
    int   lat;
    bit   found;
    exp_t e;
    lat = 1; found = 1'b0;
    while (!found && lat <= 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (res_valid) found = 1'b1;
    end
    if (!found) begin
      n_tests++; n_fail++;
      $display("FAIL res_valid_timeout: got no result within %0d edges", lat);
      return;
    end
    check_w("latency", W'(lat), W'(WORDS + 1));
    if (sb.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard_empty: result with no pending expectation");
      return;
    end
    e = sb.pop_front();
    check_w("sum", sum, e.sum);
    check_b("cout", cout, e.cout);
    check_b("ovf", ovf, e.ovf);
    check_b("busy_done", busy, 1'b1);
    check_b("start_ready_done", start_ready, 1'b0);
    for (int i = 0; i < hold; i++) begin
      start_valid = i[0];
      a_in = {$urandom, $urandom};
      @(negedge clk);
      check_b("hold_res_valid", res_valid, 1'b1);
      check_w("hold_sum", sum, e.sum);
      check_b("hold_cout", cout, e.cout);
      check_b("hold_ovf", ovf, e.ovf);
      check_b("hold_start_ready", start_ready, 1'b0);
    end
    start_valid = 1'b0;
    res_ready   = 1'b1;
    @(negedge clk);
    check_b("post_hs_res_valid", res_valid, 1'b0);
    check_b("post_hs_start_ready", start_ready, 1'b1);
    check_b("post_hs_busy", busy, 1'b0);
    check_w("post_hs_sum_kept", sum, e.sum);
  endtask

  initial begin
    vec_t  vecs[8];
    exp_t  e;
    logic [W-1:0] ra, rb;
    logic  rs, rc;

    vecs[0] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0};
    vecs[3] = '{64'h5, 64'h7, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vecs[4] = '{64'h7, 64'h5, 1'b1, 1'b0, 64'h2, 1'b1, 1'b0};
    vecs[5] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[6] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vecs[7] = '{64'hA, 64'h3, 1'b1, 1'b1, 64'h7, 1'b1, 1'b0};

    rst_n = 1'b0; start_valid = 1'b0; op_sub = 1'b0; cin = 1'b0;
    a_in = '0; b_in = '0; res_ready = 1'b1;
    #12;
    check_b("rst_res_valid", res_valid, 1'b0);
    check_b("rst_busy", busy, 1'b0);
    check_w("rst_sum", sum, 64'h0);
    check_b("rst_cout", cout, 1'b0);
    check_b("rst_ovf", ovf, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_b("rst_start_ready", start_ready, 1'b1);

    for (int i = 0; i < 8; i++) begin
      e.sum = vecs[i].e_sum; e.cout = vecs[i].e_cout; e.ovf = vecs[i].e_ovf;
      send(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, e);
      collect(0);
    end

    for (int i = 0; i < 16; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i[1:0] == 2'd0) ra[31:0] = 32'hFFFF_FFFF;
      if (i[1:0] == 2'd1) rb[47:0] = 48'h0;
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      send(ra, rb, rs, rc, model(ra, rb, rs, rc));
      collect(0);
    end

    // Backpressure: hold the result for 10 cycles, then follow with a fresh request
    res_ready = 1'b0;
    send(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b1,
         model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b1));
    collect(10);
    send(64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF, 1'b1, 1'b0,
         model(64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF, 1'b1, 1'b0));
    collect(0);

    // Reset abort while idx==2, checked before any further clock edge
    e = model(64'h0001_0002_0003_0004, 64'h0001_0001_0001_0001, 1'b0, 1'b0);
    send(64'h0001_0002_0003_0004, 64'h0001_0001_0001_0001, 1'b0, 1'b0, e);
    @(posedge clk);
    @(posedge clk);
    #1;
    check_w("mid_calc_partial_sum", sum, 64'h0000_0000_0004_0005);
    #1;
    rst_n = 1'b0;
    #1;
    check_b("abort_res_valid", res_valid, 1'b0);
    check_w("abort_sum", sum, 64'h0);
    check_b("abort_busy", busy, 1'b0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send(64'h3, 64'h4, 1'b0, 1'b0, model(64'h3, 64'h4, 1'b0, 1'b0));
    collect(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
